cozy_mem_arbiter: RTL and testbench
===================================

COZY_MEM_ARBITER -- requirements
Module: cozy_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive port-1 grants while port 0 waits (range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports m0_req  input  1, m0_addr  input  16, m0_din  input  16 and m0_bwe  input  2; these form the port-0 (CPU) request, and m0_bwe==0 marks a read.
REQ-005 SHALL have ports m0_gnt  output  1, m0_ack  output  1 and m0_dout  output  16; these are the port-0 grant, response strobe and read data.
REQ-006 SHALL have ports m1_req  input  1 and m1_addr  input  16; these form the port-1 (display fetch) request, which is read-only.
REQ-007 SHALL have ports m1_gnt  output  1, m1_ack  output  1 and m1_dout  output  16.
REQ-008 SHALL have ports mem_addr  output  16, mem_din  output  16, mem_bwe  output  2 and mem_dout  input  16; these connect to the shared synchronous memory, which has 1-cycle read latency.
REQ-009 SHALL have port starved  output  1, which is high while port 0 requests and is not granted.

Function
REQ-010 SHALL arbitrate every cycle; grant is combinational from the current req inputs and registered state.
REQ-011 SHALL grant at most one port per cycle; m0_gnt and m1_gnt are never both high.
REQ-012 SHALL grant the sole requester when only one port requests.
REQ-013 SHALL grant port 1 when both ports request, subject to REQ-022.
REQ-014 SHALL drive mem_addr, mem_din and mem_bwe from the granted port in the same cycle; port 1 forces mem_bwe=0 and mem_din=0.
REQ-015 SHALL drive mem_addr=0, mem_din=0 and mem_bwe=0 when no port is granted.
REQ-016 SHALL assert mx_ack for exactly one cycle, in the cycle after mx_gnt; the ack is registered.
REQ-017 SHALL present mem_dout on mx_dout during mx_ack for a read; the data is combinational pass-through of mem_dout.
REQ-018 SHALL drive mx_dout=0 whenever mx_ack is low.
REQ-019 SHALL assert m0_ack after a write grant, as write completion; m0_dout is then 0.
REQ-020 SHALL allow back-to-back grants: a grant in cycle N+1 may coincide with the ack of cycle N, to the same port or the other port.
REQ-021 SHALL require each requester to hold req, addr, din and bwe stable until gnt is seen; dropping req before gnt withdraws the request with no side effect.
REQ-022 SHALL keep a 4-bit run counter, run_cnt, with the following rules:
- it increments, saturating at 15, on each cycle where m1_gnt=1 and m0_req=1;
- it clears on any m0_gnt, or on any cycle with m0_req=0;
- when run_cnt==STARVE_LIMIT and both ports request, port 0 is granted instead of port 1.
REQ-023 SHALL hold the internal state (owner of the last grant: NONE/M0/M1, ack pipeline, run_cnt); the owner updates every cycle, and NONE means no grant.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force run_cnt=0, owner=NONE, m0_ack=0 and m1_ack=0.
REQ-025 SHALL, while reset_n=0, hold m0_gnt, m1_gnt, mem_bwe, mem_addr, mem_din, m0_dout, m1_dout and starved at 0, regardless of req inputs.
REQ-026 SHALL drop any ack pending when reset asserts mid-transfer; it is never delivered after reset releases.
REQ-027 SHALL begin arbitration on the first rising clk edge after reset_n deasserts, with run_cnt=0.

Configuration
REQ-028 SHALL implement the starvation guard of REQ-022 (run_cnt, and STARVE_LIMIT as effective) only when macro COZY_MEM_ARBITER_STARVE_GUARD_EN is defined.
REQ-029 SHALL, without COZY_MEM_ARBITER_STARVE_GUARD_EN, use strict port-1 priority, omit run_cnt, and ignore STARVE_LIMIT; all other requirements are unchanged.

Verification
REQ-030 SHALL cover a single read: m0_req=1, addr=0x0010, bwe=0, memory holds 0xBEEF at 0x0010 -> m0_gnt=1 and mem_addr=0x0010 in cycle 0; m0_ack=1 and m0_dout=0xBEEF in cycle 1.
REQ-031 SHALL cover a write: m0_req=1, addr=0x0020, din=0x1234, bwe=2'b11 -> mem_bwe=2'b11 and mem_din=0x1234 in the grant cycle; a read of 0x0020 afterwards returns 0x1234.
REQ-032 SHALL cover contention with the guard on and STARVE_LIMIT=4: both req held high for 10 cycles -> grant pattern m1,m1,m1,m1,m0,m1,m1,m1,m1,m0, with starved=1 exactly on cycles 0-3 and 5-8.
REQ-033 SHALL cover contention with the guard off: both req held high for 10 cycles -> m1_gnt=1 in all 10 cycles, m0_gnt never asserts, and starved=1 throughout.
REQ-034 SHALL cover reset mid-transfer: assert reset_n=0 asynchronously between an m1 grant edge and its ack -> m1_ack stays 0, all outputs are 0 immediately, and the first post-reset grant behaves as REQ-030.
REQ-035 SHALL cover alternating back-to-back traffic: m1 read at 0x0100 in cycle 0, m0 read at 0x0200 in cycle 1 -> m1_ack in cycle 1 and m0_ack in cycle 2, each carrying its own address's data, with acks never both high.

Source files
------------

// File: rtl/cozy_mem_arbiter.sv
// Two-port arbiter for a shared 1-cycle-latency synchronous memory: CPU (port 0) and display fetch (port 1).
// Build with COZY_MEM_ARBITER_STARVE_GUARD_EN to bound consecutive port-1 wins while port 0 waits.
module cozy_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_din,
  input  logic [1:0]  m0_bwe,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [15:0] m0_dout,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [15:0] m1_dout,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_bwe,
  input  logic [15:0] mem_dout,
  output logic        starved
);

  // state    | meaning
  // OWN_NONE | nothing granted last cycle, no ack due
  // OWN_M0   | port 0 granted last cycle, m0_ack due now
  // OWN_M1   | port 1 granted last cycle, m1_ack due now
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  owner_t owner_q, owner_d;
  logic   m0_rd_q;
  logic   limit_hit;

`ifdef COZY_MEM_ARBITER_STARVE_GUARD_EN
  logic [3:0] run_cnt;

  assign limit_hit = (run_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= 4'd0;
    end else if (m0_gnt || !m0_req) begin
      run_cnt <= 4'd0;
    end else if (m1_gnt && run_cnt != 4'hF) begin
      run_cnt <= run_cnt + 4'd1;
    end
  end
`else
  // Strict port-1 priority; the limit is accepted but has no effect.
  assign limit_hit = 1'b0 & (STARVE_LIMIT == 0);
`endif

  always_comb begin
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    owner_d = OWN_NONE;
    if (reset_n) begin
      if (m1_req && !(m0_req && limit_hit)) begin
        m1_gnt  = 1'b1;
        owner_d = OWN_M1;
      end else if (m0_req) begin
        m0_gnt  = 1'b1;
        owner_d = OWN_M0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
      m0_rd_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      if (m0_gnt) m0_rd_q <= (m0_bwe == 2'b00);
    end
  end

  assign m0_ack = (owner_q == OWN_M0);
  assign m1_ack = (owner_q == OWN_M1);

  // Write completions return zero on m0_dout.
  assign m0_dout = (m0_ack && m0_rd_q) ? mem_dout : 16'h0000;
  assign m1_dout = m1_ack ? mem_dout : 16'h0000;

  always_comb begin
    mem_addr = 16'h0000;
    mem_din  = 16'h0000;
    mem_bwe  = 2'b00;
    if (m0_gnt) begin
      mem_addr = m0_addr;
      mem_din  = m0_din;
      mem_bwe  = m0_bwe;
    end else if (m1_gnt) begin
      mem_addr = m1_addr;
    end
  end

  assign starved = reset_n & m0_req & ~m0_gnt;

endmodule

// File: tb/tb_cozy_mem_arbiter.sv
// Scoreboard bench for cozy_mem_arbiter: directed traffic, expected ack data queued per port.
module tb_cozy_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m1_req;
  logic [15:0] m0_addr, m0_din, m1_addr;
  logic [1:0]  m0_bwe;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack, starved;
  logic [15:0] m0_dout, m1_dout, mem_addr, mem_din, mem_dout;
  logic [1:0]  mem_bwe;

  logic [15:0] mem [0:65535];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int n_cmp = 0;
  int n_bad = 0;

  cozy_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_bwe(m0_bwe),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_addr(m1_addr),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_dout(m1_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_bwe(mem_bwe), .mem_dout(mem_dout),
    .starved(starved)
  );

  always #5 clk = ~clk;

  // Shared synchronous memory, 1-cycle read latency, byte write enables
  always @(posedge clk) begin
    mem_dout <= mem[mem_addr];
    if (mem_bwe[0]) mem[mem_addr][7:0]  <= mem_din[7:0];
    if (mem_bwe[1]) mem[mem_addr][15:8] <= mem_din[15:8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r0, input logic [15:0] a0, input logic [15:0] d0,
                        input logic [1:0] b0, input logic r1, input logic [15:0] a1);
    @(posedge clk);
    #1;
    m0_req = r0; m0_addr = a0; m0_din = d0; m0_bwe = b0;
    m1_req = r1; m1_addr = a1;
    #2;
  endtask

  task automatic idle();
    set_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0);
  endtask

  // Monitor: every ack pops the expected response for its port
  always @(negedge clk) begin
    if (m0_ack || m1_ack) chk("ack_exclusive", {31'd0, m0_ack & m1_ack}, 32'd0);
    if (m0_ack) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL m0_ack_unexpected: got ack with dout %h, expected no ack", m0_dout);
      end else chk("m0_dout", {16'd0, m0_dout}, {16'd0, q0.pop_front()});
    end
    if (m1_ack) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL m1_ack_unexpected: got ack with dout %h, expected no ack", m1_dout);
      end else chk("m1_dout", {16'd0, m1_dout}, {16'd0, q1.pop_front()});
    end
  end

  task automatic single_read();
    set_in(1'b1, 16'h0010, 16'h0, 2'b00, 1'b0, 16'h0);
    chk("rd_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("rd_mem_addr", {16'd0, mem_addr}, 32'h0010);
    q0.push_back(16'hBEEF);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0100] = 16'hCAFE;
    mem[16'h0200] = 16'h5A5A;
    mem[16'h0300] = 16'h1111;
    mem[16'h0400] = 16'h2222;

    // Reset with both requests active: everything must stay quiet
    reset_n = 1'b0;
    m0_req = 1'b1; m0_addr = 16'h0300; m0_din = 16'hFFFF; m0_bwe = 2'b11;
    m1_req = 1'b1; m1_addr = 16'h0400;
    #3;
    chk("rst_gnts", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    chk("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("rst_mem", {mem_addr, mem_din}, 32'd0);
    chk("rst_bwe_starved", {29'd0, mem_bwe, starved}, 32'd0);
    chk("rst_douts", {m0_dout, m1_dout}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    #2;
    chk("idle_mem", {mem_addr, mem_din}, 32'd0);
    chk("idle_gnts", {29'd0, m0_gnt, m1_gnt, starved}, 32'd0);

    single_read();
    idle();

    // Write then read back
    set_in(1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0, 16'h0);
    chk("wr_mem_bwe", {30'd0, mem_bwe}, 32'd3);
    chk("wr_mem_din", {16'd0, mem_din}, 32'h1234);
    chk("wr_mem_addr", {16'd0, mem_addr}, 32'h0020);
    q0.push_back(16'h0000);
    set_in(1'b1, 16'h0020, 16'h0, 2'b00, 1'b0, 16'h0);
    chk("rb_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    q0.push_back(16'h1234);
    idle();

    // Contention for 10 cycles
    for (int i = 0; i < 10; i++) begin
      logic exp0;
`ifdef COZY_MEM_ARBITER_STARVE_GUARD_EN
      exp0 = (i == 4 || i == 9);
`else
      exp0 = 1'b0;
`endif
      set_in(1'b1, 16'h0300, 16'h0, 2'b00, 1'b1, 16'h0400);
      chk($sformatf("cont_gnt_%0d", i), {30'd0, m0_gnt, m1_gnt}, {30'd0, exp0, ~exp0});
      chk($sformatf("cont_starved_%0d", i), {31'd0, starved}, {31'd0, ~exp0});
      chk($sformatf("cont_mem_addr_%0d", i), {16'd0, mem_addr}, exp0 ? 32'h0300 : 32'h0400);
      if (exp0) q0.push_back(16'h1111);
      else      q1.push_back(16'h2222);
    end
    idle();

    // Alternating back-to-back reads
    set_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'h0100);
    chk("alt_c0_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
    q1.push_back(16'hCAFE);
    set_in(1'b1, 16'h0200, 16'h0, 2'b00, 1'b0, 16'h0);
    chk("alt_c1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    chk("alt_c1_m1_ack", {31'd0, m1_ack}, 32'd1);
    q0.push_back(16'h5A5A);
    idle();
    chk("alt_c2_m0_ack", {31'd0, m0_ack}, 32'd1);
    idle();

    // Reset asserted inside an m1 grant cycle: its ack must never appear
    set_in(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'h0100);
    chk("rm_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rm_gnts", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    chk("rm_mem", {mem_addr, mem_din}, 32'd0);
    chk("rm_bwe_starved_douts", {13'd0, mem_bwe, starved, m0_dout}, 32'd0);
    @(posedge clk); #1;
    chk("rm_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rm_m1_dout", {16'd0, m1_dout}, 32'd0);
    m1_req = 1'b0;
    reset_n = 1'b1;
    #2;
    chk("rm_post_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    single_read();
    idle();
    idle();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
